// File: rtl/hamming_pkg.sv
// Shared types for the SECDED decode engine: FSM states, result flags and
// the Hamming-position map of the eleven message bits.
package hamming_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        F_OK  = 2'b00,
        F_SGL = 2'b01,
        F_DBL = 2'b10
    } flag_t;

    // Entry j is the codeword position carrying message bit d[j+1].
    localparam logic [10:0][3:0] DATA_POS = {
        4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
    };

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder for one 16-bit codeword (positions 15..1 plus
// overall parity in bit 0): corrects single errors, flags double errors.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [15:0] cw,
    output logic [11:1] d,
    output flag_t       F
);

    logic [3:0]  w_syn;
    logic        w_par;
    logic [15:0] w_fix;

    always_comb begin
        w_syn = '0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) w_syn = w_syn ^ 4'(k);
        end
        w_par = ^cw;

        // An odd parity error is a single hit; syndrome 0 means p0 itself.
        w_fix = cw;
        if (w_par && (w_syn != 4'd0)) w_fix[w_syn] = ~cw[w_syn];

        if (w_par)                F = F_SGL;
        else if (w_syn != 4'd0)   F = F_DBL;
        else                      F = F_OK;

        d = '0;
        for (int j = 0; j < 11; j++) begin
            d[j+1] = w_fix[DATA_POS[j]];
        end
    end

endmodule

// File: rtl/hamming_decode_engine.sv
// Memory-mastering engine: reads NUM_WORDS SECDED codewords, decodes each and
// writes {message, status} back, counting corrected and uncorrectable words.
module hamming_decode_engine
    import hamming_pkg::*;
#(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [7:0]    sgl_cnt,
    output logic [7:0]    dbl_cnt
);

    localparam logic [AW-1:0] SRC = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST = AW'(DST_BASE);

    state_t        r_state;
    logic [6:0]    r_idx;
    logic          r_done;
    logic [AW-1:0] r_addr;
    logic          r_wr_en;
    logic [7:0]    r_wr_data;
    logic [7:0]    r_sgl;
    logic [7:0]    r_dbl;
    logic [7:0]    r_lo;
    logic [2:0]    r_dat_hi;
    flag_t         r_flag;

    logic [AW-1:0] w_off;
    logic [AW-1:0] w_off_nx;
    logic [11:1]   w_dec_d;
    flag_t         w_dec_f;
    logic          w_last;

    assign w_off    = AW'({r_idx, 1'b0});
    assign w_off_nx = AW'({r_idx + 7'd1, 1'b0});
    assign w_last   = (r_idx == 7'(NUM_WORDS - 1));

    // Decoder sees the hi byte straight off the bus while in RD_HI.
    hamming_secded_dec u_dec (
        .cw ({mem_rd_data, r_lo}),
        .d  (w_dec_d),
        .F  (w_dec_f)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_sgl     <= '0;
            r_dbl     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (req) begin
                        r_state <= S_RD_LO;
                        r_idx   <= '0;
                        r_sgl   <= '0;
                        r_dbl   <= '0;
                        r_done  <= 1'b0;
                        r_addr  <= SRC;
                    end
                end
                S_RD_LO: begin
                    r_state <= S_RD_HI;
                    r_addr  <= SRC + w_off + AW'(1);
                end
                S_RD_HI: begin
                    r_state   <= S_WR_LO;
                    r_addr    <= DST + w_off;
                    r_wr_en   <= 1'b1;
                    r_wr_data <= w_dec_d[8:1];
                end
                S_WR_LO: begin
                    r_state   <= S_WR_HI;
                    r_addr    <= DST + w_off + AW'(1);
                    r_wr_data <= {r_flag, 3'b000, r_dat_hi};
                end
                S_WR_HI: begin
                    r_wr_en <= 1'b0;
                    if (r_flag == F_SGL) r_sgl <= sat_inc(r_sgl);
                    if (r_flag == F_DBL) r_dbl <= sat_inc(r_dbl);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                    end else begin
                        r_state <= S_RD_LO;
                        r_idx   <= r_idx + 7'd1;
                        r_addr  <= SRC + w_off_nx;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_RD_LO) r_lo <= mem_rd_data;
        if (r_state == S_RD_HI) begin
            r_dat_hi <= w_dec_d[11:9];
            r_flag   <= w_dec_f;
        end
    end

    assign done        = r_done;
    assign mem_addr    = r_addr;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_data = r_wr_data;
    assign sgl_cnt     = r_sgl;
    assign dbl_cnt     = r_dbl;

endmodule

// File: tb/tb_hamming_decode_engine.sv
// Bench for hamming_decode_engine: table-driven codeword runs against a model
// built from the injected error pattern, plus handshake and mid-run reset.
module tb_hamming_decode_engine;

    localparam int NW  = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] sgl_cnt;
    logic [7:0] dbl_cnt;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       ld_all = 1'b0;

    typedef struct {
        logic [10:0] data;
        logic [15:0] mask;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    vec_t tbl [NW];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hamming_decode_engine #(
        .NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt)
    );

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (ld_all) begin
            for (int a = 0; a < 256; a++) mem[a] = img[a];
        end else if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_pow2(input int k);
        return (k & (k - 1)) == 0;
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw;
        logic        p;
        int          j;
        cw = '0;
        j  = 0;
        for (int k = 1; k < 16; k++) begin
            if (!is_pow2(k)) begin
                cw[k] = d[j];
                j++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            p = 1'b0;
            for (int k = 1; k < 16; k++) begin
                if (((k >> b) & 1) == 1 && k != (1 << b)) p = p ^ cw[k];
            end
            cw[1 << b] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] cw);
        logic [10:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int k = 1; k < 16; k++) begin
            if (!is_pow2(k)) begin
                d[j] = cw[k];
                j++;
            end
        end
        return d;
    endfunction

    // Expected {hi, lo} from the message and how many bits were disturbed.
    function automatic logic [15:0] expect_bytes(input logic [10:0] d, input logic [15:0] mask);
        logic [10:0] out;
        logic [1:0]  f;
        int          n;
        n = $countones(mask);
        if (n == 0) begin
            f = 2'b00; out = d;
        end else if (n == 1) begin
            f = 2'b01; out = d;
        end else begin
            f = 2'b10; out = extract(encode(d) ^ mask);
        end
        return {f, 3'b000, out[10:8], out[7:0]};
    endfunction

    task automatic fill_random(input int first, input bit clean);
        logic [15:0] e;
        int          n, p1, p2;
        for (int i = first; i < NW; i++) begin
            tbl[i].data = 11'($urandom);
            tbl[i].mask = '0;
            if (!clean) begin
                n = int'($urandom_range(0, 2));
                if (n >= 1) begin
                    p1 = int'($urandom_range(0, 15));
                    tbl[i].mask[p1] = 1'b1;
                end
                if (n == 2) begin
                    do p2 = int'($urandom_range(0, 15)); while (p2 == p1);
                    tbl[i].mask[p2] = 1'b1;
                end
            end
            e = expect_bytes(tbl[i].data, tbl[i].mask);
            tbl[i].lo = e[7:0];
            tbl[i].hi = e[15:8];
        end
    endtask

    task automatic load_image();
        logic [15:0] cw;
        for (int a = 0; a < 256; a++) img[a] = 8'hEE;
        for (int i = 0; i < NW; i++) begin
            cw = encode(tbl[i].data) ^ tbl[i].mask;
            img[SRC + 2*i]     = cw[7:0];
            img[SRC + 2*i + 1] = cw[15:8];
        end
        @(negedge clk); ld_all = 1'b1;
        @(negedge clk); ld_all = 1'b0;
    endtask

    task automatic start_req();
        @(posedge clk); #1;
        req = 1'b1;
    endtask

    // Cycle 1 is the first cycle after the edge that accepts req.
    task automatic run_to_done(input int pulse_at, output int cyc);
        @(posedge clk); #1;
        cyc = 1;
        chk("done_low_after_req", 32'(done), 32'd0);
        req = 1'b0;
        while (done !== 1'b1 && cyc < 400) begin
            req = (cyc == pulse_at);
            @(posedge clk); #1;
            cyc++;
        end
        req = 1'b0;
    endtask

    task automatic check_dst(input int nw);
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("lo_byte_w%0d", i), 32'(mem[DST + 2*i]), 32'(tbl[i].lo));
            chk($sformatf("hi_byte_w%0d", i), 32'(mem[DST + 2*i + 1]), 32'(tbl[i].hi));
        end
    endtask

    task automatic check_counts(input string tag);
        int es, ed;
        es = 0; ed = 0;
        for (int i = 0; i < NW; i++) begin
            if (tbl[i].hi[7:6] == 2'b01) es++;
            if (tbl[i].hi[7:6] == 2'b10) ed++;
        end
        chk({tag, "_sgl_cnt"}, 32'(sgl_cnt), 32'(es));
        chk({tag, "_dbl_cnt"}, 32'(dbl_cnt), 32'(ed));
    endtask

    initial begin
        int cyc;
        bit found;

        #12;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wr_data", 32'(mem_wr_data), 32'd0);
        chk("rst_sgl", 32'(sgl_cnt), 32'd0);
        chk("rst_dbl", 32'(dbl_cnt), 32'd0);
        @(negedge clk); reset = 1'b1;

        // Clean codewords
        fill_random(0, 1'b1);
        load_image();
        start_req();
        run_to_done(-1, cyc);
        chk("clean_done_cycle", 32'(cyc), 32'd61);
        check_dst(NW);
        chk("clean_sgl_cnt", 32'(sgl_cnt), 32'd0);
        chk("clean_dbl_cnt", 32'(dbl_cnt), 32'd0);

        // Directed error cases followed by random 0/1/2-bit errors; busy req pulse ignored
        tbl[0] = '{11'h5A3, 16'h0200, 8'hA3, 8'h45};
        tbl[1] = '{11'h7FF, 16'h0001, 8'hFF, 8'h47};
        tbl[2] = '{11'h001, 16'h1008, 8'h80, 8'h80};
        fill_random(3, 1'b0);
        load_image();
        start_req();
        run_to_done(20, cyc);
        chk("pulse20_done_cycle", 32'(cyc), 32'd61);
        check_dst(NW);
        check_counts("errs");

        // req held while in DONE restarts immediately
        load_image();
        chk("done_held", 32'(done), 32'd1);
        req = 1'b1;
        run_to_done(-1, cyc);
        chk("restart_done_cycle", 32'(cyc), 32'd61);
        check_dst(NW);
        check_counts("restart");

        // Reset during word 7's WR_LO
        fill_random(0, 1'b0);
        load_image();
        start_req();
        @(posedge clk); #1;
        req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (mem_wr_en && mem_addr == 8'(DST + 14)) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("reach_w7_wr_lo", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_sgl", 32'(sgl_cnt), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_wr_en", 32'(mem_wr_en), 32'd0);
        chk("idle_addr", 32'(mem_addr), 32'd0);
        check_dst(7);
        chk("w7_lo_untouched", 32'(mem[DST + 14]), 32'hEE);
        chk("w7_hi_untouched", 32'(mem[DST + 15]), 32'hEE);

        // Engine accepts a fresh run after the abort
        start_req();
        run_to_done(-1, cyc);
        chk("post_rst_done_cycle", 32'(cyc), 32'd61);
        check_dst(NW);
        check_counts("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
